// File: rtl/parity_frame_checker.sv
// Serial parity frame checker: sof-marked LSB-first data bits, then one parity bit.
// Result is visible one cycle after the parity bit; no backpressure (bit_valid only).
module parity_frame_checker #(
  parameter int DATA_W     = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              sof,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy,
  output logic [7:0]        err_count
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  shift_dat;
  logic               run_par;

  logic start;
  logic abort;
  logic take_data;
  logic complete;
  logic frame_perr;
  logic last_bit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bit_valid && sof) state_nxt = DATA;
      end
      DATA: begin
        if (bit_valid) begin
          if (sof)           state_nxt = DATA;
          else if (last_bit) state_nxt = PARITY;
        end
      end
      PARITY: begin
        if (bit_valid) state_nxt = sof ? DATA : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A sof always restarts the frame, whatever state we are in.
  always_comb begin
    start      = bit_valid && sof;
    abort      = start && (state != IDLE);
    take_data  = bit_valid && !sof && (state == DATA);
    complete   = bit_valid && !sof && (state == PARITY);
    last_bit   = (cnt == CNT_W'(DATA_W - 1));
    frame_perr = ((run_par ^ bit_in) != ODD_PARITY);
    busy       = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      shift_dat  <= '0;
      run_par    <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      err_count  <= 8'd0;
    end else begin
      data_valid <= complete;
      frame_err  <= abort;
      if (start) begin
        shift_dat <= {{(DATA_W-1){1'b0}}, bit_in};
        run_par   <= bit_in;
        cnt       <= CNT_W'(1);
      end else if (take_data) begin
        shift_dat[cnt] <= bit_in;
        run_par        <= run_par ^ bit_in;
        cnt            <= last_bit ? '0 : cnt + CNT_W'(1);
      end
      if (complete) begin
        data_out   <= shift_dat;
        parity_err <= frame_perr;
        if (frame_perr && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Bench for parity_frame_checker: even and odd instances share stimulus,
// checked every cycle against a frame-level reference model.
module tb_parity_frame_checker;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         bit_in;
  logic         bit_valid;
  logic         sof;
  logic [W-1:0] dout_e, dout_o;
  logic         dv_e, dv_o, pe_e, pe_o, fe_e, fe_o, busy_e, busy_o;
  logic [7:0]   ec_e, ec_o;

  parity_frame_checker #(.DATA_W(W), .ODD_PARITY(1'b0)) dut_e (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
    .data_out(dout_e), .data_valid(dv_e), .parity_err(pe_e), .frame_err(fe_e),
    .busy(busy_e), .err_count(ec_e)
  );

  parity_frame_checker #(.DATA_W(W), .ODD_PARITY(1'b1)) dut_o (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
    .data_out(dout_o), .data_valid(dv_o), .parity_err(pe_o), .frame_err(fe_o),
    .busy(busy_o), .err_count(ec_o)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: what each output should show, tracked per frame.
  logic [W-1:0] m_data;
  logic         m_pe_e, m_pe_o;
  int           m_ec_e, m_ec_o;
  bit           m_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input bit dv_exp, input bit fe_exp);
    chk("dv_even",   32'(dv_e),   32'(dv_exp));
    chk("dv_odd",    32'(dv_o),   32'(dv_exp));
    chk("fe_even",   32'(fe_e),   32'(fe_exp));
    chk("fe_odd",    32'(fe_o),   32'(fe_exp));
    chk("busy_even", 32'(busy_e), 32'(m_busy));
    chk("busy_odd",  32'(busy_o), 32'(m_busy));
    chk("dout_even", 32'(dout_e), 32'(m_data));
    chk("dout_odd",  32'(dout_o), 32'(m_data));
    chk("pe_even",   32'(pe_e),   32'(m_pe_e));
    chk("pe_odd",    32'(pe_o),   32'(m_pe_o));
    chk("ec_even",   32'(ec_e),   32'(m_ec_e));
    chk("ec_odd",    32'(ec_o),   32'(m_ec_o));
  endtask

  task automatic model_reset();
    m_data = '0;
    m_pe_e = 1'b0;
    m_pe_o = 1'b0;
    m_ec_e = 0;
    m_ec_o = 0;
    m_busy = 1'b0;
  endtask

  task automatic cycle(input bit v, input bit b, input bit s);
    bit_valid = v;
    bit_in    = b;
    sof       = s;
    @(posedge clk);
    #1;
  endtask

  // Idle cycles with garbage on the don't-care inputs.
  task automatic gap(input int n);
    for (int k = 0; k < n; k++) begin
      cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check_all(1'b0, 1'b0);
    end
  endtask

  task automatic send_bits(input logic [W-1:0] data, input int n, input int gmax);
    bit fe;
    for (int i = 0; i < n; i++) begin
      if (i > 0) gap($urandom_range(0, gmax));
      fe = (i == 0) && m_busy;
      cycle(1'b1, data[i], i == 0);
      m_busy = 1'b1;
      check_all(1'b0, fe);
    end
  endtask

  task automatic send_frame(input logic [W-1:0] data, input bit par, input int gmax);
    bit x;
    send_bits(data, W, gmax);
    gap($urandom_range(0, gmax));
    cycle(1'b1, par, 1'b0);
    x      = ^data ^ par;
    m_busy = 1'b0;
    m_data = data;
    m_pe_e = (x != 1'b0);
    m_pe_o = (x != 1'b1);
    if (m_pe_e && m_ec_e < 255) m_ec_e++;
    if (m_pe_o && m_ec_o < 255) m_ec_o++;
    check_all(1'b1, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    // Inputs must be ignored while in reset.
    cycle(1'b1, 1'b1, 1'b1);
    model_reset();
    check_all(1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    check_all(1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    sof       = 1'b0;
    model_reset();
    do_reset();

    // Stray bits without sof in IDLE are ignored.
    cycle(1'b1, 1'b1, 1'b0);
    check_all(1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    check_all(1'b0, 1'b0);

    send_frame(8'hA5, 1'b0, 0);
    chk("a5_dout", 32'(dout_e), 32'h0000_00A5);
    chk("a5_pe",   32'(pe_e),   32'd0);
    gap(1);

    send_frame(8'h01, 1'b0, 0);
    chk("01_pe", 32'(pe_e), 32'd1);
    chk("01_ec", 32'(ec_e), 32'd1);
    gap(2);

    send_frame(8'h00, 1'b1, 0);
    chk("odd_ok",  32'(pe_o), 32'd0);
    send_frame(8'h00, 1'b0, 0);
    chk("odd_bad", 32'(pe_o), 32'd1);
    gap(1);

    // Abort after four bits, restart with a good frame.
    send_bits(8'hE7, 4, 2);
    send_frame(8'h3C, 1'b0, 0);
    chk("abort_dout", 32'(dout_e), 32'h0000_003C);
    chk("abort_pe",   32'(pe_e),   32'd0);

    // Back-to-back frames with random gaps inside each frame.
    send_frame(8'h12, 1'b0, 5);
    send_frame(8'h34, 1'b1, 5);
    chk("b2b_dout", 32'(dout_e), 32'h0000_0034);
    gap(1);

    // Random frames, random parity, random gaps, occasional abort.
    for (int f = 0; f < 25; f++) begin
      if ($urandom_range(0, 4) == 0) send_bits(8'($urandom), $urandom_range(1, W), 3);
      send_frame(8'($urandom), 1'($urandom_range(0, 1)), 5);
      gap($urandom_range(0, 2));
    end

    // Saturation of the error counter.
    for (int f = 0; f < 300; f++) send_frame(8'h01, 1'b0, 0);
    chk("sat_ec", 32'(ec_e), 32'd255);
    gap(1);

    // Reset mid-frame drops the partial frame silently.
    send_bits(8'h5A, 5, 1);
    do_reset();
    send_frame(8'hFF, 1'b0, 0);
    chk("post_rst_dout", 32'(dout_e), 32'h0000_00FF);
    chk("post_rst_pe",   32'(pe_e),   32'd0);
    gap(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parity_frame_checker.md
PARITY_FRAME_CHECKER -- requirements
Module: parity_frame_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 8, number of data bits per frame (legal 2..32).
REQ-002 SHALL have parameter ODD_PARITY, default 0; 0 = even parity, 1 = odd parity.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port bit_in  input  1  serial data or parity bit.
REQ-006 SHALL have port bit_valid  input  1  bit_in is sampled on cycles where this is 1.
REQ-007 SHALL have port sof  input  1  start-of-frame; qualified by bit_valid; marks data bit 0.
REQ-008 SHALL have port data_out  output  DATA_W  last completed frame's data, bit 0 = first bit received.
REQ-009 SHALL have port data_valid  output  1  one-cycle pulse when data_out/parity_err are updated.
REQ-010 SHALL have port parity_err  output  1  parity result of last completed frame; held until next completion.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse when an in-progress frame is aborted by sof.
REQ-012 SHALL have port busy  output  1  1 while a frame is in progress (state DATA or PARITY).
REQ-013 SHALL have port err_count  output  8  saturating count of frames completed with parity_err = 1.

Function
REQ-014 SHALL implement FSM states IDLE, DATA, PARITY.
REQ-015 IDLE: bit_valid=1 and sof=1 SHALL store bit_in as data bit 0, set bit counter to 1, enter DATA (or PARITY if DATA_W=1 is ever allowed -- not legal, see REQ-001).
REQ-016 IDLE: bit_valid=1 with sof=0 SHALL be ignored; no output changes.
REQ-017 DATA: each bit_valid=1 with sof=0 SHALL store bit_in at index = counter, increment counter; after index DATA_W-1 is stored, enter PARITY.
REQ-018 Cycles with bit_valid=0 SHALL hold all state (arbitrary gaps between bits allowed).
REQ-019 Running parity SHALL be the XOR of all accepted data bits, cleared at each frame start.
REQ-020 PARITY: bit_valid=1 with sof=0 SHALL take bit_in as parity bit; frame completes; return to IDLE.
REQ-021 On completion, parity_err SHALL = (running XOR ^ parity bit) != ODD_PARITY.
REQ-022 On completion, data_out, parity_err and data_valid=1 SHALL be visible on the cycle after the parity bit is sampled (latency 1); data_valid deasserts the following cycle.
REQ-023 err_count SHALL increment by 1 on the same cycle parity_err updates to 1, saturating at 255.
REQ-024 DATA or PARITY: bit_valid=1 with sof=1 SHALL abort the current frame, pulse frame_err for one cycle (next cycle), and restart exactly as REQ-015 with this bit as data bit 0; data_out/parity_err unchanged; no data_valid.
REQ-025 A completion on cycle N and a new sof on cycle N+1 SHALL both be handled (back-to-back frames, no dead cycle).
REQ-026 busy SHALL be 1 the cycle after a frame starts through the cycle the parity bit is sampled; 0 in IDLE.
REQ-027 bit_in, sof SHALL be don't-care when bit_valid=0.

Reset
REQ-028 With rst_n=0 at a rising clk edge, state SHALL become IDLE, counter 0, running parity 0.
REQ-029 Reset values SHALL be: data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0, err_count=0.
REQ-030 Reset mid-frame SHALL discard the partial frame with no data_valid or frame_err pulse.
REQ-031 Inputs SHALL be ignored while rst_n=0; first frame may start on the first cycle with rst_n=1.

Verification
REQ-032 Even, DATA_W=8: send 0xA5 LSB-first (sof on bit 0) then parity 0 -> data_valid pulse, data_out=0xA5, parity_err=0, err_count=0.
REQ-033 Even, DATA_W=8: send 0x01 then parity 0 -> data_out=0x01, parity_err=1, err_count=1; repeat 300 times -> err_count=255.
REQ-034 Odd, DATA_W=8: send 0x00 then parity 1 -> parity_err=0; then 0x00 with parity 0 -> parity_err=1.
REQ-035 Send 4 data bits of a frame, then sof with new frame 0x3C + correct parity -> frame_err one pulse, then data_valid with data_out=0x3C, parity_err=0.
REQ-036 Random bit_valid gaps (0..5 idle cycles) and back-to-back frames 0x12, 0x34 -> two data_valid pulses, data_out 0x12 then 0x34, latency 1 after each parity bit.
REQ-037 Assert rst_n=0 after 5 data bits -> all outputs at reset values; next full frame 0xFF + parity 0 -> data_out=0xFF, parity_err=0.
